// File: rtl/rvv_core_pkg.sv
// rvv_core_pkg: shared types for the vector backend.
// RVV_TB_SUPPORT_EN adds a trace pc to xrf_t and lsu_req_t.
package rvv_core_pkg;

  localparam int VLEN = 128;
  localparam int NE   = VLEN / 32;

  localparam logic [2:0] OP_VADD_VV   = 3'd0;
  localparam logic [2:0] OP_VADD_VX   = 3'd1;
  localparam logic [2:0] OP_VSADDU_VV = 3'd2;
  localparam logic [2:0] OP_VMV_X_S   = 3'd3;
  localparam logic [2:0] OP_VLE       = 3'd4;
  localparam logic [2:0] OP_VSE       = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_XRF,
    S_VXSAT,
    S_LSU_REQ,
    S_LSU_RSP
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  op;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [31:0] rs1_data;
  } inst_t;

  typedef struct packed {
`ifdef RVV_TB_SUPPORT_EN
    logic [31:0] uop_pc;
`endif
    logic [4:0]  rd_index;
    logic [31:0] rd_data;
  } xrf_t;

  typedef struct packed {
`ifdef RVV_TB_SUPPORT_EN
    logic [31:0]     uop_pc;
`endif
    logic [31:0]     addr;
    logic            is_store;
    logic [4:0]      vidx;
    logic [VLEN-1:0] data;
  } lsu_req_t;

  typedef struct packed {
    logic [4:0]      vidx;
    logic [VLEN-1:0] data;
  } lsu_rsp_t;

endpackage

// File: rtl/rvv_core_cmdq.sv
// rvv_core_cmdq: command FIFO with flush and occupancy count.
// Caller guarantees no push when full and no pop when empty.
module rvv_core_cmdq #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // storage, wrapping pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rvv_backend_core.sv
// rvv_backend_core: in-order vector backend, queue + FSM + VRF.
// RVV_TB_SUPPORT_EN copies the instruction pc into output trace fields.
module rvv_backend_core
  import rvv_core_pkg::*;
#(
  parameter int CQ_DEPTH = 4,
  parameter int CW       = $clog2(CQ_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          insts_valid_rvs2cq,
  input  inst_t         insts_rvs2cq,
  output logic          insts_ready_cq2rvs,
  output logic [CW-1:0] remaining_count_cq2rvs,
  output xrf_t          rt_xrf_rvv2rvs,
  output logic          rt_xrf_valid_rvv2rvs,
  input  logic          rt_xrf_ready_rvs2rvv,
  output logic          uop_lsu_valid_rvv2lsu,
  output lsu_req_t      uop_lsu_rvv2lsu,
  input  logic          uop_lsu_ready_lsu2rvv,
  input  logic          uop_lsu_valid_lsu2rvv,
  input  lsu_rsp_t      uop_lsu_lsu2rvv,
  output logic          uop_lsu_ready_rvv2lsu,
  input  logic          trap_valid_rvs2rvv,
  output logic          trap_ready_rvv2rvs,
  output logic          wr_vxsat_valid,
  output logic          wr_vxsat,
  input  logic          wr_vxsat_ready,
  output logic          vcsr_valid,
  output logic [31:0]   vector_csr,
  input  logic          vcsr_ready,
  output logic          rvv_idle
);

  state_e          state;
  state_e          state_nxt;
  inst_t           ir;
  inst_t           cq_head;
  logic            cq_full;
  logic            cq_empty;
  logic [CW-1:0]   cq_count;
  logic [VLEN-1:0] vrf [32];
  logic            push;
  logic            pop;
  logic            trap_fire;
  logic            rsp_fire;
  logic            alu_wr;
  logic [VLEN-1:0] alu_res;
  logic            alu_sat;

  assign trap_ready_rvv2rvs = !vcsr_valid;
  assign trap_fire  = trap_valid_rvs2rvv && trap_ready_rvv2rvs;
  assign insts_ready_cq2rvs = !cq_full && !trap_valid_rvs2rvv;
  assign push       = insts_valid_rvs2cq && insts_ready_cq2rvs;
  assign pop        = (state == S_IDLE) && !cq_empty && !trap_fire;
  assign rsp_fire   = (state == S_LSU_RSP) && uop_lsu_valid_lsu2rvv
                      && !trap_fire;
  assign alu_wr     = (state == S_EXEC) && !trap_fire
                      && (ir.op <= OP_VSADDU_VV);
  assign remaining_count_cq2rvs = CW'(CQ_DEPTH) - cq_count;
  assign rvv_idle   = cq_empty && (state == S_IDLE) && !vcsr_valid;

  rvv_core_cmdq #(
    .DEPTH (CQ_DEPTH),
    .W     ($bits(inst_t)),
    .CW    (CW)
  ) u_cmdq (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (trap_fire),
    .push  (push),
    .din   (insts_rvs2cq),
    .pop   (pop),
    .dout  (cq_head),
    .full  (cq_full),
    .empty (cq_empty),
    .count (cq_count)
  );

  // per-element add, saturating for vsaddu
  always_comb begin
    logic [32:0] s;
    s       = '0;
    alu_res = '0;
    alu_sat = 1'b0;
    for (int e = 0; e < NE; e++) begin
      s = {1'b0, vrf[ir.vs2][e*32 +: 32]}
        + ((ir.op == OP_VADD_VX) ? {1'b0, ir.rs1_data}
                                 : {1'b0, vrf[ir.vs1][e*32 +: 32]});
      if (ir.op == OP_VSADDU_VV && s[32]) begin
        alu_sat = 1'b1;
        alu_res[e*32 +: 32] = '1;
      end else begin
        alu_res[e*32 +: 32] = s[31:0];
      end
    end
  end

  // state and instruction register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (pop) ir <= cq_head;
    end
  end

  // next state; a trap always returns to idle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!cq_empty) state_nxt = S_EXEC;
      S_EXEC: begin
        case (ir.op)
          OP_VSADDU_VV: state_nxt = alu_sat ? S_VXSAT : S_IDLE;
          OP_VMV_X_S:   state_nxt = S_XRF;
          OP_VLE,
          OP_VSE:       state_nxt = S_LSU_REQ;
          default:      state_nxt = S_IDLE;
        endcase
      end
      S_XRF:     if (rt_xrf_ready_rvs2rvv) state_nxt = S_IDLE;
      S_VXSAT:   if (wr_vxsat_ready) state_nxt = S_IDLE;
      S_LSU_REQ: if (uop_lsu_ready_lsu2rvv) state_nxt = S_LSU_RSP;
      S_LSU_RSP: if (uop_lsu_valid_lsu2rvv) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (trap_fire) state_nxt = S_IDLE;
  end

  // handshake outputs decoded from state
  always_comb begin
    rt_xrf_rvv2rvs          = '0;
    uop_lsu_rvv2lsu         = '0;
    rt_xrf_valid_rvv2rvs    = (state == S_XRF);
    wr_vxsat_valid          = (state == S_VXSAT);
    wr_vxsat                = (state == S_VXSAT);
    uop_lsu_valid_rvv2lsu   = (state == S_LSU_REQ);
    uop_lsu_ready_rvv2lsu   = (state == S_LSU_RSP);
    rt_xrf_rvv2rvs.rd_index = ir.vd;
    rt_xrf_rvv2rvs.rd_data  = vrf[ir.vs2][31:0];
    uop_lsu_rvv2lsu.addr     = ir.rs1_data;
    uop_lsu_rvv2lsu.is_store = (ir.op == OP_VSE);
    uop_lsu_rvv2lsu.vidx     = ir.vd;
    if (ir.op == OP_VSE) uop_lsu_rvv2lsu.data = vrf[ir.vd];
`ifdef RVV_TB_SUPPORT_EN
    rt_xrf_rvv2rvs.uop_pc  = ir.pc;
    uop_lsu_rvv2lsu.uop_pc = ir.pc;
`endif
  end

  // VRF writes from the ALU or a load response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) vrf[i] <= '0;
    end else if (alu_wr) begin
      vrf[ir.vd] <= alu_res;
    end else if (rsp_fire && ir.op == OP_VLE) begin
      vrf[uop_lsu_lsu2rvv.vidx] <= uop_lsu_lsu2rvv.data;
    end
  end

  // post-trap report of the aborted pc
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vcsr_valid <= 1'b0;
      vector_csr <= '0;
    end else if (trap_fire) begin
      vcsr_valid <= 1'b1;
      vector_csr <= (state == S_IDLE) ? 32'd0 : ir.pc;
    end else if (vcsr_ready) begin
      vcsr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rvv_backend_core.sv
// tb_rvv_backend_core: scoreboard bench for rvv_backend_core.
// Expected xrf/lsu results are queued at issue and popped on handshake.
module tb_rvv_backend_core;
  import rvv_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        insts_valid_rvs2cq = 1'b0;
  inst_t       insts_rvs2cq = '0;
  logic        insts_ready_cq2rvs;
  logic [2:0]  remaining_count_cq2rvs;
  xrf_t        rt_xrf_rvv2rvs;
  logic        rt_xrf_valid_rvv2rvs;
  logic        rt_xrf_ready_rvs2rvv = 1'b1;
  logic        uop_lsu_valid_rvv2lsu;
  lsu_req_t    uop_lsu_rvv2lsu;
  logic        uop_lsu_ready_lsu2rvv = 1'b1;
  logic        uop_lsu_valid_lsu2rvv = 1'b0;
  lsu_rsp_t    uop_lsu_lsu2rvv = '0;
  logic        uop_lsu_ready_rvv2lsu;
  logic        trap_valid_rvs2rvv = 1'b0;
  logic        trap_ready_rvv2rvs;
  logic        wr_vxsat_valid;
  logic        wr_vxsat;
  logic        wr_vxsat_ready = 1'b1;
  logic        vcsr_valid;
  logic [31:0] vector_csr;
  logic        vcsr_ready = 1'b0;
  logic        rvv_idle;

  rvv_backend_core dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .insts_valid_rvs2cq     (insts_valid_rvs2cq),
    .insts_rvs2cq           (insts_rvs2cq),
    .insts_ready_cq2rvs     (insts_ready_cq2rvs),
    .remaining_count_cq2rvs (remaining_count_cq2rvs),
    .rt_xrf_rvv2rvs         (rt_xrf_rvv2rvs),
    .rt_xrf_valid_rvv2rvs   (rt_xrf_valid_rvv2rvs),
    .rt_xrf_ready_rvs2rvv   (rt_xrf_ready_rvs2rvv),
    .uop_lsu_valid_rvv2lsu  (uop_lsu_valid_rvv2lsu),
    .uop_lsu_rvv2lsu        (uop_lsu_rvv2lsu),
    .uop_lsu_ready_lsu2rvv  (uop_lsu_ready_lsu2rvv),
    .uop_lsu_valid_lsu2rvv  (uop_lsu_valid_lsu2rvv),
    .uop_lsu_lsu2rvv        (uop_lsu_lsu2rvv),
    .uop_lsu_ready_rvv2lsu  (uop_lsu_ready_rvv2lsu),
    .trap_valid_rvs2rvv     (trap_valid_rvs2rvv),
    .trap_ready_rvv2rvs     (trap_ready_rvv2rvs),
    .wr_vxsat_valid         (wr_vxsat_valid),
    .wr_vxsat               (wr_vxsat),
    .wr_vxsat_ready         (wr_vxsat_ready),
    .vcsr_valid             (vcsr_valid),
    .vector_csr             (vector_csr),
    .vcsr_ready             (vcsr_ready),
    .rvv_idle               (rvv_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } xrf_exp_t;

  typedef struct {
    logic [31:0]     addr;
    logic            st;
    logic [4:0]      vidx;
    logic [VLEN-1:0] data;
  } lsu_exp_t;

  xrf_exp_t        exp_xrf[$];
  lsu_exp_t        exp_lsu[$];
  logic [VLEN-1:0] mv [32];
  int              n_chk = 0;
  int              n_pass = 0;
  int              vxsat_hs = 0;
  int              exp_vxsat = 0;

  task automatic check(input string tag, input logic [VLEN-1:0] got,
                       input logic [VLEN-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // scoreboard: compare outputs on each handshake
  always @(negedge clk) begin : mon
    xrf_exp_t x;
    lsu_exp_t l;
    if (rst_n) begin
      if (rt_xrf_valid_rvv2rvs && rt_xrf_ready_rvs2rvv) begin
        if (exp_xrf.size() == 0) begin
          check("xrf_extra", 1, 0);
        end else begin
          x = exp_xrf.pop_front();
          check("xrf_idx", rt_xrf_rvv2rvs.rd_index, x.idx);
          check("xrf_data", rt_xrf_rvv2rvs.rd_data, x.data);
        end
      end
      if (uop_lsu_valid_rvv2lsu && uop_lsu_ready_lsu2rvv) begin
        if (exp_lsu.size() == 0) begin
          check("lsu_extra", 1, 0);
        end else begin
          l = exp_lsu.pop_front();
          check("lsu_addr", uop_lsu_rvv2lsu.addr, l.addr);
          check("lsu_store", uop_lsu_rvv2lsu.is_store, l.st);
          check("lsu_vidx", uop_lsu_rvv2lsu.vidx, l.vidx);
          if (l.st) check("lsu_data", uop_lsu_rvv2lsu.data, l.data);
        end
      end
      if (wr_vxsat_valid && wr_vxsat_ready) vxsat_hs++;
    end
  end

  function automatic inst_t mk(input logic [2:0] op, input logic [4:0] vd,
                               input logic [4:0] vs1, input logic [4:0] vs2,
                               input logic [31:0] rs1, input logic [31:0] pc);
    inst_t i;
    i = '0;
    i.pc = pc;
    i.op = op;
    i.vd = vd;
    i.vs1 = vs1;
    i.vs2 = vs2;
    i.rs1_data = rs1;
    return i;
  endfunction

  task automatic send(input inst_t i);
    int n;
    n = 0;
    @(posedge clk); #1;
    insts_valid_rvs2cq = 1'b1;
    insts_rvs2cq = i;
    do begin
      @(negedge clk);
      n++;
    end while (!insts_ready_cq2rvs && n < 100);
    check("push_ready", insts_ready_cq2rvs, 1);
    @(posedge clk); #1;
    insts_valid_rvs2cq = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] vd,
                       input logic [4:0] vs1, input logic [4:0] vs2,
                       input logic [31:0] rs1, input logic [31:0] pc);
    logic [VLEN-1:0] r;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [32:0]     s;
    logic            sat;
    r = '0;
    sat = 1'b0;
    case (op)
      OP_VADD_VV, OP_VADD_VX, OP_VSADDU_VV: begin
        for (int e = 0; e < NE; e++) begin
          a = mv[vs2][e*32 +: 32];
          b = (op == OP_VADD_VX) ? rs1 : mv[vs1][e*32 +: 32];
          s = {1'b0, a} + {1'b0, b};
          if (op == OP_VSADDU_VV && s[32]) begin
            r[e*32 +: 32] = 32'hFFFF_FFFF;
            sat = 1'b1;
          end else begin
            r[e*32 +: 32] = s[31:0];
          end
        end
        mv[vd] = r;
        if (sat) exp_vxsat++;
      end
      OP_VMV_X_S: exp_xrf.push_back('{vd, mv[vs2][31:0]});
      OP_VLE:     exp_lsu.push_back('{rs1, 1'b0, vd, {VLEN{1'b0}}});
      OP_VSE:     exp_lsu.push_back('{rs1, 1'b1, vd, mv[vd]});
      default: ;
    endcase
    send(mk(op, vd, vs1, vs2, rs1, pc));
  endtask

  task automatic wait_for(input string tag, input int which);
    int   n;
    logic hit;
    n = 0;
    hit = 1'b0;
    do begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = rvv_idle;
        1:       hit = rt_xrf_valid_rvv2rvs;
        2:       hit = wr_vxsat_valid;
        default: hit = uop_lsu_ready_rvv2lsu;
      endcase
    end while (!hit && n < 200);
    if (!hit) check(tag, 0, 1);
  endtask

  task automatic lsu_respond(input logic [4:0] vidx,
                             input logic [VLEN-1:0] d);
    wait_for("lsu_rsp_wait", 3);
    @(posedge clk); #1;
    uop_lsu_valid_lsu2rvv = 1'b1;
    uop_lsu_lsu2rvv.vidx = vidx;
    uop_lsu_lsu2rvv.data = d;
    @(posedge clk); #1;
    uop_lsu_valid_lsu2rvv = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mv[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", insts_ready_cq2rvs, 1);
    check("rst_remaining", remaining_count_cq2rvs, 4);
    check("rst_idle", rvv_idle, 1);
    check("rst_xrf_valid", rt_xrf_valid_rvv2rvs, 0);
    check("rst_lsu_valid", uop_lsu_valid_rvv2lsu, 0);
    check("rst_vcsr", {vcsr_valid, vector_csr}, 0);
    check("rst_trap_ready", trap_ready_rvv2rvs, 1);
    check("rst_vxsat", wr_vxsat_valid, 0);

    // VADD_VX v1 = v0 + 5, pipeline timing seen through rvv_idle
    issue(OP_VADD_VX, 5'd1, 5'd0, 5'd0, 32'd5, 32'h10);
    @(negedge clk);
    check("vadd_idle_n", rvv_idle, 0);
    @(negedge clk);
    check("vadd_idle_n1", rvv_idle, 0);
    @(negedge clk);
    check("vadd_idle_n2", rvv_idle, 1);
    issue(OP_VSE, 5'd1, 5'd0, 5'd0, 32'h200, 32'h14);
    lsu_respond(5'd1, {VLEN{1'b1}});
    wait_for("idle_vse1", 0);

    // saturating add with a stalled vxsat handshake
    issue(OP_VADD_VX, 5'd3, 5'd0, 5'd0, 32'hFFFF_FFF0, 32'h18);
    issue(OP_VADD_VX, 5'd4, 5'd0, 5'd0, 32'h20, 32'h1c);
    wr_vxsat_ready = 1'b0;
    issue(OP_VSADDU_VV, 5'd5, 5'd4, 5'd3, 32'd0, 32'h20);
    wait_for("vxsat_rise", 2);
    repeat (3) begin
      @(negedge clk);
      check("vxsat_hold", {wr_vxsat_valid, wr_vxsat}, 2'b11);
    end
    @(posedge clk); #1 wr_vxsat_ready = 1'b1;
    @(posedge clk); #1;
    check("vxsat_drop", wr_vxsat_valid, 0);
    issue(OP_VSE, 5'd5, 5'd0, 5'd0, 32'h240, 32'h24);
    lsu_respond(5'd5, '0);
    issue(OP_VSADDU_VV, 5'd6, 5'd4, 5'd4, 32'd0, 32'h28);
    issue(OP_VADD_VV, 5'd8, 5'd4, 5'd3, 32'd0, 32'h2c);
    issue(OP_VMV_X_S, 5'd9, 5'd0, 5'd6, 32'd0, 32'h30);
    issue(OP_VMV_X_S, 5'd24, 5'd0, 5'd8, 32'd0, 32'h34);
    wait_for("idle_sat", 0);
    check("vxsat_count", vxsat_hs, exp_vxsat);

    // VMV_X_S holds valid while ready is low
    issue(OP_VADD_VX, 5'd1, 5'd0, 5'd0, 32'd7, 32'h38);
    rt_xrf_ready_rvs2rvv = 1'b0;
    issue(OP_VMV_X_S, 5'd3, 5'd0, 5'd1, 32'd0, 32'h3c);
    wait_for("xrf_rise", 1);
    repeat (2) begin
      @(negedge clk);
      check("xrf_hold", rt_xrf_valid_rvv2rvs, 1);
    end
    @(posedge clk); #1 rt_xrf_ready_rvs2rvv = 1'b1;
    wait_for("idle_xrf", 0);

    // illegal op leaves v1 untouched
    send(mk(3'd6, 5'd1, 5'd0, 5'd0, 32'd99, 32'h50));
    issue(OP_VMV_X_S, 5'd25, 5'd0, 5'd1, 32'd0, 32'h54);
    wait_for("idle_illegal", 0);

    // fill the queue behind a stalled XRF
    rt_xrf_ready_rvs2rvv = 1'b0;
    issue(OP_VMV_X_S, 5'd10, 5'd0, 5'd1, 32'd0, 32'h60);
    wait_for("fill_xrf", 1);
    for (int i = 0; i < 4; i++)
      issue(OP_VADD_VX, 5'(11 + i), 5'd0, 5'd0, 32'(i + 1), 32'h64);
    @(negedge clk);
    check("full_ready", insts_ready_cq2rvs, 0);
    check("full_remaining", remaining_count_cq2rvs, 0);
    @(posedge clk); #1;
    insts_valid_rvs2cq = 1'b1;
    insts_rvs2cq = mk(OP_VMV_X_S, 5'd20, 5'd0, 5'd1, 32'd0, 32'h74);
    repeat (3) @(negedge clk);
    check("fifth_blocked", insts_ready_cq2rvs, 0);
    @(posedge clk); #1;
    insts_valid_rvs2cq = 1'b0;
    rt_xrf_ready_rvs2rvv = 1'b1;
    wait_for("idle_drain", 0);
    check("drain_remaining", remaining_count_cq2rvs, 4);
    issue(OP_VMV_X_S, 5'd23, 5'd0, 5'd14, 32'd0, 32'h78);

    // VLE writes v2, then VSE reads it back
    issue(OP_VLE, 5'd2, 5'd0, 5'd0, 32'h100, 32'h80);
    mv[2] = {NE{32'hDEAD_BEEF}};
    lsu_respond(5'd2, mv[2]);
    issue(OP_VSE, 5'd2, 5'd0, 5'd0, 32'h180, 32'h84);
    lsu_respond(5'd2, '0);
    wait_for("idle_lsu", 0);

    // trap while waiting for a load response
    issue(OP_VLE, 5'd7, 5'd0, 5'd0, 32'h300, 32'h40);
    send(mk(OP_VMV_X_S, 5'd21, 5'd0, 5'd2, 32'd0, 32'h44));
    wait_for("trap_rsp_wait", 3);
    @(posedge clk); #1;
    trap_valid_rvs2rvv = 1'b1;
    uop_lsu_valid_lsu2rvv = 1'b1;
    uop_lsu_lsu2rvv.vidx = 5'd7;
    uop_lsu_lsu2rvv.data = {NE{32'h1234_5678}};
    @(negedge clk);
    check("trap_ready", trap_ready_rvv2rvs, 1);
    check("trap_push_block", insts_ready_cq2rvs, 0);
    @(posedge clk); #1;
    uop_lsu_valid_lsu2rvv = 1'b0;
    @(negedge clk);
    check("trap_vcsr", {vcsr_valid, vector_csr}, {1'b1, 32'h40});
    check("trap_blocked", trap_ready_rvv2rvs, 0);
    check("trap_rsp_drop", uop_lsu_ready_rvv2lsu, 0);
    check("trap_flush", remaining_count_cq2rvs, 4);
    repeat (2) begin
      @(negedge clk);
      check("vcsr_hold", {vcsr_valid, vector_csr}, {1'b1, 32'h40});
    end
    @(posedge clk); #1;
    trap_valid_rvs2rvv = 1'b0;
    vcsr_ready = 1'b1;
    @(posedge clk); #1;
    vcsr_ready = 1'b0;
    @(negedge clk);
    check("vcsr_clear", vcsr_valid, 0);
    check("trap_idle", rvv_idle, 1);
    issue(OP_VMV_X_S, 5'd22, 5'd0, 5'd7, 32'd0, 32'h88);
    wait_for("idle_post_trap", 0);

    // trap with nothing in flight reports pc 0
    @(posedge clk); #1 trap_valid_rvs2rvv = 1'b1;
    @(posedge clk); #1 trap_valid_rvs2rvv = 1'b0;
    @(negedge clk);
    check("idle_trap_vcsr", {vcsr_valid, vector_csr}, {1'b1, 32'h0});
    @(posedge clk); #1 vcsr_ready = 1'b1;
    @(posedge clk); #1 vcsr_ready = 1'b0;
    @(negedge clk);
    check("idle_trap_done", rvv_idle, 1);

    repeat (3) @(negedge clk);
    check("xrf_left", exp_xrf.size(), 0);
    check("lsu_left", exp_lsu.size(), 0);
    check("vxsat_final", vxsat_hs, exp_vxsat);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
